// File: rtl/ccl_merge_controller_pkg.sv
// Shared word size, stack sizing and controller state encodings for the CCL merge path.
package ccl_merge_controller_pkg;

  localparam int WORD_SIZE           = 8;
  localparam int STACK_DEPTH_DEFAULT = 64;

  // MERGE is split into POP/FIND_HI/FIND_LO/LINK sub-states.
  typedef enum logic [2:0] {
    CCL_S_IDLE    = 3'd0,
    CCL_S_COLLECT = 3'd1,
    CCL_S_POP     = 3'd2,
    CCL_S_FIND_HI = 3'd3,
    CCL_S_FIND_LO = 3'd4,
    CCL_S_LINK    = 3'd5,
    CCL_S_FLATTEN = 3'd6,
    CCL_S_DONE    = 3'd7
  } ccl_state_e;

endpackage

// File: rtl/ccl_merge_controller_if.sv
// Labeler / downstream-facing bus of the merge controller.
interface ccl_merge_controller_if #(
  parameter int WIDTH = ccl_merge_controller_pkg::WORD_SIZE
);

  logic             frame_start;
  logic             frame_end;
  logic             new_label;
  logic             merge_valid;
  logic [WIDTH-1:0] merge_hi;
  logic [WIDTH-1:0] merge_lo;
  logic [WIDTH-1:0] lookup_addr;
  logic [WIDTH-1:0] lookup_data;
  logic [WIDTH-1:0] num_labels;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [WIDTH-1:0] num_components;

  modport master (
    output frame_start, frame_end, new_label, merge_valid, merge_hi, merge_lo, lookup_addr,
    input  lookup_data, num_labels, busy, done, overflow, num_components
  );

  modport slave (
    input  frame_start, frame_end, new_label, merge_valid, merge_hi, merge_lo, lookup_addr,
    output lookup_data, num_labels, busy, done, overflow, num_components
  );

endinterface

// File: rtl/ccl_merge_controller_stack.sv
// LIFO holding merge pairs; top entry is visible combinationally, pop just drops it.
module ccl_merge_controller_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    top_idx;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign top_idx = AW'(count_q - 1'b1);
  assign top_o   = mem_q[top_idx];
  assign do_push = push_i && !full_o && !clear_i;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[count_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/ccl_merge_controller.sv
// Label-equivalence table for CCL: collects merge pairs, resolves them by union-find, then flattens.
// Optional CCL_COMPONENT_COUNT_EN adds a root counter during FLATTEN; otherwise num_components is 0.
module ccl_merge_controller
  import ccl_merge_controller_pkg::*;
#(
  parameter int WIDTH       = WORD_SIZE,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input logic                   clk,
  input logic                   reset_n,
  ccl_merge_controller_if.slave bus
);

  localparam int DEPTH = 1 << WIDTH;
  localparam int PW    = 2 * WIDTH;

  ccl_state_e       state_q;
  logic [WIDTH-1:0] num_labels_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] root_hi_q;
  logic [WIDTH-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;

  logic [WIDTH-1:0] table_q [DEPTH];
  logic             tbl_we;
  logic [WIDTH-1:0] tbl_waddr;
  logic [WIDTH-1:0] tbl_wdata;
  logic [WIDTH-1:0] rd_r;
  logic [WIDTH-1:0] rd_idx;
  logic [WIDTH-1:0] rd_idx2;

  logic             in_collect;
  logic             start_frame;
  logic             pair_ok;
  logic             label_sat;
  logic             stack_push;
  logic             stack_pop;
  logic             stack_empty;
  logic             stack_full;
  logic [PW-1:0]    stack_top;

  assign in_collect  = (state_q == CCL_S_COLLECT);
  assign start_frame = bus.frame_start && (state_q == CCL_S_IDLE || state_q == CCL_S_DONE);
  assign pair_ok     = in_collect && bus.merge_valid && (bus.merge_hi != '0) &&
                       (bus.merge_lo != '0) && (bus.merge_hi != bus.merge_lo);
  assign label_sat   = (num_labels_q == WIDTH'(DEPTH - 1));
  assign stack_push  = pair_ok && !stack_full;
  assign stack_pop   = (state_q == CCL_S_POP) && !stack_empty;

  ccl_merge_controller_stack #(
    .WIDTH (PW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (start_frame),
    .push_i      (stack_push),
    .push_data_i ({bus.merge_hi, bus.merge_lo}),
    .pop_i       (stack_pop),
    .top_o       (stack_top),
    .empty_o     (stack_empty),
    .full_o      (stack_full)
  );

  assign rd_r    = table_q[r_q];
  assign rd_idx  = table_q[idx_q];
  assign rd_idx2 = table_q[rd_idx];

  assign bus.lookup_data = (bus.lookup_addr == '0) ? '0 : table_q[bus.lookup_addr];
  assign bus.num_labels  = num_labels_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

  // Only one of COLLECT, LINK or FLATTEN can be active, so the table sees one write per cycle.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    case (state_q)
      CCL_S_COLLECT: begin
        tbl_we    = bus.new_label;
        tbl_waddr = num_labels_q;
        tbl_wdata = num_labels_q;
      end
      CCL_S_LINK: begin
        tbl_we    = (root_hi_q != r_q);
        tbl_waddr = (root_hi_q > r_q) ? root_hi_q : r_q;
        tbl_wdata = (root_hi_q > r_q) ? r_q : root_hi_q;
      end
      CCL_S_FLATTEN: begin
        tbl_we    = (num_labels_q != WIDTH'(1));
        tbl_waddr = idx_q;
        tbl_wdata = rd_idx2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_q[tbl_waddr] <= tbl_wdata;
    end
  end

`ifdef CCL_COMPONENT_COUNT_EN
  logic [WIDTH-1:0] comp_q;
  assign bus.num_components = comp_q;
`else
  assign bus.num_components = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= CCL_S_IDLE;
      num_labels_q <= WIDTH'(1);
      r_q          <= '0;
      lo_q         <= '0;
      root_hi_q    <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef CCL_COMPONENT_COUNT_EN
      comp_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CCL_S_IDLE, CCL_S_DONE: begin
          if (bus.frame_start) begin
            state_q      <= CCL_S_COLLECT;
            num_labels_q <= WIDTH'(1);
            overflow_q   <= 1'b0;
`ifdef CCL_COMPONENT_COUNT_EN
            comp_q       <= '0;
`endif
          end
        end
        CCL_S_COLLECT: begin
          if (bus.new_label && !label_sat) begin
            num_labels_q <= num_labels_q + 1'b1;
          end
          if ((bus.new_label && label_sat) || (pair_ok && stack_full)) begin
            overflow_q <= 1'b1;
          end
          if (bus.frame_end) begin
            state_q <= CCL_S_POP;
            busy_q  <= 1'b1;
          end
        end
        CCL_S_POP: begin
          if (stack_empty) begin
            state_q <= CCL_S_FLATTEN;
            idx_q   <= WIDTH'(1);
          end else begin
            r_q     <= stack_top[PW-1:WIDTH];
            lo_q    <= stack_top[WIDTH-1:0];
            state_q <= CCL_S_FIND_HI;
          end
        end
        CCL_S_FIND_HI: begin
          if (rd_r == r_q) begin
            root_hi_q <= r_q;
            r_q       <= lo_q;
            state_q   <= CCL_S_FIND_LO;
          end else begin
            r_q <= rd_r;
          end
        end
        CCL_S_FIND_LO: begin
          // r_q is left holding the low root for LINK.
          if (rd_r == r_q) begin
            state_q <= CCL_S_LINK;
          end else begin
            r_q <= rd_r;
          end
        end
        CCL_S_LINK: begin
          state_q <= CCL_S_POP;
        end
        CCL_S_FLATTEN: begin
`ifdef CCL_COMPONENT_COUNT_EN
          if (num_labels_q != WIDTH'(1) && rd_idx == idx_q) begin
            comp_q <= comp_q + 1'b1;
          end
`endif
          if (num_labels_q == WIDTH'(1) || idx_q == num_labels_q - 1'b1) begin
            state_q <= CCL_S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= CCL_S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccl_merge_controller.sv
// Randomized scoreboard bench: expected label maps come from component-minimum propagation.
`timescale 1ns/1ps
module tb_ccl_merge_controller;
  import ccl_merge_controller_pkg::*;

  localparam int W  = WORD_SIZE;
  localparam int SD = 64;

  typedef struct {
    int nlab;
    int ovf;
    int ncomp;
  } exp_t;

  logic clk;
  logic reset_n;

  ccl_merge_controller_if #(.WIDTH(W)) bus();

  ccl_merge_controller #(.WIDTH(W), .STACK_DEPTH(SD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   frames_pushed  = 0;
  int   frames_checked = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  int   exp_map_q[$];
  int   pend_hi[$];
  int   pend_lo[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Monitor: each done pulse is matched against the oldest expected frame.
  initial begin
    exp_t e;
    int   want;
    bus.lookup_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("num_labels", int'(bus.num_labels), e.nlab);
          check("overflow_done", int'(bus.overflow), e.ovf);
          check("num_components", int'(bus.num_components), e.ncomp);
          check("busy_at_done", int'(bus.busy), 0);
          bus.lookup_addr = '0;
          #1;
          check("lookup_0", int'(bus.lookup_data), 0);
          for (int x = 1; x < e.nlab; x++) begin
            bus.lookup_addr = W'(x);
            #1;
            want = exp_map_q.pop_front();
            $display("frame %0d lookup %0d -> %0d (expected %0d)", frames_checked, x, bus.lookup_data, want);
            check("lookup", int'(bus.lookup_data), want);
          end
          bus.lookup_addr = '0;
          frames_checked++;
        end
      end
    end
  end

  // Drives one frame: nl label allocations and the pend_* pairs, frame_end on the last event.
  task automatic run_frame(input int nl, input bit rnd);
    int np, li, pi, pushed, ovf, cnt, ncomp;
    bit do_l, do_p, last, changed;
    int acc_hi[$];
    int acc_lo[$];
    int comp[256];
    int h, l, m;
    exp_t e;
    np = pend_hi.size(); li = 0; pi = 0; pushed = 0; ovf = 0;
    @(posedge clk); #1;
    bus.frame_start = 1'b1;
    do begin
      @(posedge clk); #1;
      check("overflow_live", int'(bus.overflow), ovf);
      bus.frame_start = rnd && ($urandom_range(0, 15) == 0);
      do_l = (li < nl) && (!rnd || $urandom_range(0, 3) != 0);
      do_p = (pi < np) && (!rnd || $urandom_range(0, 2) != 0);
      bus.new_label   = do_l;
      bus.merge_valid = do_p;
      bus.merge_hi    = do_p ? W'(pend_hi[pi]) : W'($urandom_range(0, 255));
      bus.merge_lo    = do_p ? W'(pend_lo[pi]) : W'($urandom_range(0, 255));
      if (do_p) begin
        h = pend_hi[pi]; l = pend_lo[pi];
        if (h != 0 && l != 0 && h != l) begin
          if (pushed < SD) begin
            acc_hi.push_back(h); acc_lo.push_back(l); pushed++;
          end else ovf = 1;
        end
      end
      li += int'(do_l); pi += int'(do_p);
      last = (li == nl) && (pi == np);
      bus.frame_end = last;
    end while (!last);
    @(posedge clk); #1;
    bus.frame_start = 0; bus.frame_end = 0; bus.new_label = 0; bus.merge_valid = 0;
    check("overflow_live", int'(bus.overflow), ovf);
    check("busy_merge", int'(bus.busy), 1);
    for (int x = 0; x <= nl; x++) comp[x] = x;
    do begin
      changed = 0;
      for (int k = 0; k < acc_hi.size(); k++) begin
        m = (comp[acc_hi[k]] < comp[acc_lo[k]]) ? comp[acc_hi[k]] : comp[acc_lo[k]];
        if (comp[acc_hi[k]] != m || comp[acc_lo[k]] != m) changed = 1;
        comp[acc_hi[k]] = m; comp[acc_lo[k]] = m;
      end
    end while (changed);
    ncomp = 0;
    for (int x = 1; x <= nl; x++) begin
      exp_map_q.push_back(comp[x]);
      if (comp[x] == x) ncomp++;
    end
`ifndef CCL_COMPONENT_COUNT_EN
    ncomp = 0;
`endif
    e.nlab = nl + 1; e.ovf = ovf; e.ncomp = ncomp;
    exp_q.push_back(e);
    frames_pushed++;
    cnt = 0;
    while (frames_checked < frames_pushed && cnt < 5000) begin
      @(posedge clk); cnt++;
    end
    check("frame_completed", frames_checked, frames_pushed);
    #1;
    check("done_pulses", done_cnt, frames_pushed);
    $display("frame %0d: labels=%0d pairs=%0d accepted=%0d overflow=%0d", frames_pushed, nl, np, pushed, ovf);
    pend_hi.delete(); pend_lo.delete();
  endtask

  task automatic add_pair(input int a, input int b);
    pend_hi.push_back(a > b ? a : b);
    pend_lo.push_back(a > b ? b : a);
  endtask

  initial begin
    int nl, np, a, b, d0;
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, np, a, b, d0;
    reset_n = 1'b0;
    bus.frame_start = 0; bus.frame_end = 0; bus.new_label = 0; bus.merge_valid = 0;
    bus.merge_hi = '0; bus.merge_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_num_labels", int'(bus.num_labels), 1);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_num_components", int'(bus.num_components), 0);
    reset_n = 1'b1;

    run_frame(3, 0);
    add_pair(2, 1); add_pair(4, 3); add_pair(4, 2);
    run_frame(4, 0);
    add_pair(3, 2); add_pair(2, 1);
    run_frame(3, 0);
    // 64 pairs fill the stack; the 65th (10,1) must be dropped.
    for (int k = 0; k < SD; k++) begin
      a = $urandom_range(1, 9);
      b = 1 + ((a + $urandom_range(0, 7)) % 9);
      add_pair(a, b);
    end
    add_pair(10, 1);
    run_frame(10, 0);
    run_frame(0, 1);

    for (int f = 0; f < 12; f++) begin
      nl = $urandom_range(1, 40);
      np = $urandom_range(0, 30);
      for (int k = 0; k < np; k++) begin
        a = $urandom_range(0, nl); b = $urandom_range(0, nl);
        add_pair(a, b);
      end
      run_frame(nl, 1);
    end

    // Reset while FLATTEN walks 60 labels.
    @(posedge clk); #1;
    bus.frame_start = 1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      bus.frame_start = 0; bus.new_label = 1; bus.frame_end = (k == 59);
    end
    @(posedge clk); #1;
    bus.new_label = 0; bus.frame_end = 0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_flatten", int'(bus.busy), 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst6_busy", int'(bus.busy), 0);
    check("rst6_done", int'(bus.done), 0);
    check("rst6_num_labels", int'(bus.num_labels), 1);
    check("rst6_overflow", int'(bus.overflow), 0);
    repeat (80) @(posedge clk);
    #1;
    check("rst6_no_done", done_cnt, d0);

    add_pair(5, 2); add_pair(2, 1);
    run_frame(6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
